fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 12, meaning program-counter width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address stack depth.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE and HALT.
REQ-006 SHALL have port imem_data  input  9  instruction word from the synchronous ROM, valid one cycle after pc_o.
REQ-007 SHALL have port done  input  1  halt indication from the decoder.
REQ-008 SHALL have port jump2sub  input  1  subroutine call from the decoder.
REQ-009 SHALL have port sub_target  input  PC_W  call destination.
REQ-010 SHALL have port ret_en  input  1  subroutine return request.
REQ-011 SHALL have port br_take  input  1  branch/jump taken, resolved by the register stage.
REQ-012 SHALL have port br_target  input  PC_W  branch destination.
REQ-013 SHALL have port pc_o  output  PC_W  ROM address.
REQ-014 SHALL have port instr  output  9  registered instruction to the decoder.
REQ-015 SHALL have port instr_vld  output  1  instr is valid and executing this cycle.
REQ-016 SHALL have port halted  output  1  the block is in HALT.
REQ-017 SHALL have port stack_err  output  1  sticky RAS overflow/underflow flag.

Function
REQ-018 SHALL implement states IDLE, FETCH, EXEC and HALT.
REQ-019 IDLE: when start=1, SHALL set pc_o=0, clear stack_err, empty the RAS and go to FETCH; otherwise SHALL stay in IDLE.
REQ-020 FETCH: SHALL hold pc_o for exactly one cycle, then go to EXEC while loading imem_data into instr.
REQ-021 EXEC: SHALL assert instr_vld for exactly one cycle, then go to FETCH, or to HALT when done=1; each instruction takes 2 cycles.
REQ-022 In EXEC, the next pc SHALL follow this priority: done (pc held) > jump2sub (push pc+1, pc=sub_target) > ret_en (pc=popped value) > br_take (pc=br_target) > pc+1.
REQ-023 pc+1 SHALL wrap modulo 2^PC_W (all-ones -> 0), both for sequential fetch and for the pushed return address.
REQ-024 A push with RAS_DEPTH entries already stored SHALL leave the stack unchanged, set stack_err and still jump to sub_target.
REQ-025 A pop on an empty stack SHALL set stack_err and take pc+1.
REQ-026 HALT: SHALL assert halted; start=1 SHALL restart exactly as REQ-019.
REQ-027 instr_vld SHALL be 0 in IDLE, FETCH and HALT; control inputs SHALL be ignored outside EXEC.
REQ-028 stack_err SHALL stay set until the next reset or restart.

Reset
REQ-029 Assertion of reset_n=0 SHALL immediately set: state IDLE, pc_o=0, instr=0, instr_vld=0, halted=0, stack_err=0, RAS empty.
REQ-030 Reset mid-EXEC SHALL discard any pending push, pop or branch.
REQ-031 The first start SHALL be honoured no earlier than the first rising edge after deassertion.

Structure
REQ-032 The fetch-state enum, PC_W and RAS_DEPTH defaults SHALL live in instr_pack.
REQ-033 The return-address stack SHALL be a sub-module ret_stack (push, pop, full, empty, top).

Verification
REQ-034 Reset, start=1 -> pc_o sequence 0,1,2 on every second cycle; instr_vld high in EXEC only.
REQ-035 jump2sub at pc=5, sub_target=0x100, later ret_en -> pc 0x100, then 6 on return.
REQ-036 Five nested calls with RAS_DEPTH=4 -> stack_err=1 on the fifth call; jump still taken. A return with empty stack at pc=9 -> pc=10, stack_err=1.
REQ-037 pc=0xFFF sequential -> next pc 0x000; call at 0xFFF pushes 0x000.
REQ-038 done and br_take both asserted in EXEC -> HALT with pc held; start -> pc=0.
REQ-039 reset_n pulsed low mid-EXEC with jump2sub=1 -> IDLE, RAS empty, no pc change on the next edge.

Source files
------------

// File: rtl/instr_pack.sv
// Shared definitions for the instruction fetch block.
//   PC_W_DEF, RAS_DEPTH_DEF : default program-counter width / return-stack depth
//   INSTR_W                 : instruction word width from the ROM
//   fetch_state_e           : fetch sequencer states
//   exec_ctrl_t             : decoder/register-stage controls sampled in EXEC
package instr_pack;

    localparam int PC_W_DEF      = 12;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int INSTR_W       = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic done;
        logic call;
        logic ret;
        logic br;
    } exec_ctrl_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack (LIFO).
//   clk, reset_n : clock, async active-low reset (empties the stack)
//   clr          : synchronous empty, wins over push/pop
//   push, din    : store din; ignored when full
//   pop          : discard top entry; ignored when empty
//   full, empty  : occupancy flags
//   top          : most recently pushed entry (0 when empty)
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]             cnt;
    logic [DEPTH-1:0][W-1:0]   stk;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              cnt <= '0;
        else if (clr)              cnt <= '0;
        else if (push && !full)    cnt <= cnt + CW'(1);
        else if (pop && !empty)    cnt <= cnt - CW'(1);
    end

    // Entry storage needs no reset: cnt alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            for (int i = 0; i < DEPTH; i++)
                if (cnt == CW'(i)) stk[i] <= din;
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (cnt == CW'(i + 1)) top = stk[i];
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-cycle instruction fetch sequencer with return-address stack.
//   clk, reset_n      : clock, async active-low reset
//   start             : run request (IDLE / HALT)
//   imem_data         : synchronous ROM data for pc_o
//   done, jump2sub, sub_target, ret_en, br_take, br_target : EXEC controls
//   pc_o              : ROM address
//   instr, instr_vld  : registered instruction, high during EXEC
//   halted            : in HALT
//   stack_err         : sticky stack overflow/underflow
module fetch_unit
    import instr_pack::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               done,
    input  logic               jump2sub,
    input  logic [PC_W-1:0]    sub_target,
    input  logic               ret_en,
    input  logic               br_take,
    input  logic [PC_W-1:0]    br_target,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_vld,
    output logic               halted,
    output logic               stack_err
);

    fetch_state_e       state, state_nxt;
    logic [PC_W-1:0]    pc_q, pc_nxt, pc_inc;
    logic [INSTR_W-1:0] instr_q, instr_nxt;
    logic               err_q, err_nxt;
    logic               ras_clr, ras_push, ras_pop, ras_full, ras_empty;
    logic [PC_W-1:0]    ras_top;
    exec_ctrl_t         ctrl;

    assign ctrl   = '{done: done, call: jump2sub, ret: ret_en, br: br_take};
    assign pc_inc = pc_q + PC_W'(1);   // wraps all-ones -> 0

    ret_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (ras_clr),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (pc_inc),
        .full    (ras_full),
        .empty   (ras_empty),
        .top     (ras_top)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        err_nxt   = err_q;
        ras_clr   = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    err_nxt   = 1'b0;
                    ras_clr   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                instr_nxt = imem_data;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (ctrl.done) begin
                    state_nxt = HALT;          // pc held
                end else begin
                    state_nxt = FETCH;
                    if (ctrl.call) begin
                        // Overflow drops the return address but still jumps.
                        if (ras_full) err_nxt  = 1'b1;
                        else          ras_push = 1'b1;
                        pc_nxt = sub_target;
                    end else if (ctrl.ret) begin
                        if (ras_empty) begin
                            err_nxt = 1'b1;
                            pc_nxt  = pc_inc;
                        end else begin
                            ras_pop = 1'b1;
                            pc_nxt  = ras_top;
                        end
                    end else if (ctrl.br) begin
                        pc_nxt = br_target;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pc_o      = pc_q;
    assign instr     = instr_q;
    assign instr_vld = (state == EXEC);
    assign halted    = (state == HALT);
    assign stack_err = err_q;

endmodule
